crypt_frame_ctrl: RTL and testbench

Frame controller and two-way arbiter for the serial encryption link. It accepts bytes from two requesters, arbitrates round-robin, and emits framed one-bit-per-clock streams: sync word, source bit, then a fixed-length payload. The output bit stream is the plaintext input of `data_encrypt`. The frame flags let the receive side re-align `data_decrypt` output.

---
 rtl/crypt_link_pkg.sv | 19 +
 rtl/rr_arb2.sv | 41 ++++
 rtl/crypt_frame_ctrl.sv | 170 +++++++++++++++++
 tb/tb_crypt_frame_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/crypt_link_pkg.sv
// Shared definitions for the serial encryption link framer: state encoding,
// default preamble and frame-length helper.
package crypt_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SYNC    = 2'd1,
    ST_SRC     = 2'd2,
    ST_PAYLOAD = 2'd3
  } frame_state_e;

  localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hA5;

  // Valid bits per frame: 8 sync + 1 source + 8 per payload byte.
  function automatic int unsigned frame_len(input int unsigned payload_bytes);
    return 32'd9 + 32'd8 * payload_bytes;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter. The pointer names the requester that wins
// a tie and flips to the other side whenever a grant is taken.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  logic ptr_r;
  logic gnt_idx_s;

  // Grant selection: single request wins outright, a tie goes to the pointer.
  always_comb begin
    gnt_idx_s = 1'b0;
    if (req == 2'b11) begin
      gnt_idx_s = ptr_r;
    end else if (req == 2'b10) begin
      gnt_idx_s = 1'b1;
    end else begin
      gnt_idx_s = 1'b0;
    end
  end

  assign gnt_valid = |req;
  assign gnt_idx   = gnt_idx_s;

  // Pointer register, moved past the winner on every taken grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= 1'b0;
    end else if (upd && gnt_valid) begin
      ptr_r <= ~gnt_idx_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/crypt_frame_ctrl.sv
// Frame controller: arbitrates two byte requesters and serialises
// sync word, source bit and a fixed-length payload one bit per clock.
module crypt_frame_ctrl
  import crypt_link_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD     = SYNC_WORD_DEFAULT,
  parameter int         PAYLOAD_BYTES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic [7:0] i_data0,
  input  logic [7:0] i_data1,
  output logic       o_ack0,
  output logic       o_ack1,
  output logic       o_bit,
  output logic       o_valid,
  output logic       o_sof,
  output logic       o_eof,
  output logic       o_src
);

  localparam int             BW        = $clog2(PAYLOAD_BYTES + 1);
  localparam logic [BW-1:0]  LAST_BYTE = BW'(PAYLOAD_BYTES - 1);

  frame_state_e  state_r, state_nxt_s;
  logic [2:0]    bit_cnt_r, bit_cnt_nxt_s;
  logic [BW-1:0] byte_cnt_r, byte_cnt_nxt_s;
  logic [7:0]    shift_r, shift_nxt_s;
  logic          bit_r, bit_nxt_s;
  logic          valid_r, valid_nxt_s;
  logic          sof_r, sof_nxt_s;
  logic          eof_r, eof_nxt_s;
  logic          src_r, src_nxt_s;

  logic          gnt_valid_s, gnt_idx_s;
  logic          fetch_cycle_s, ack0_s, ack1_s;
  logic [7:0]    fetch_byte_s;

  rr_arb2 u_arb (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .req       ({i_req1, i_req0}),
    .upd       (state_r == ST_IDLE),
    .gnt_valid (gnt_valid_s),
    .gnt_idx   (gnt_idx_s)
  );

  // Byte fetch: SRC cycle for byte 0, LSB cycle of each non-final byte after.
  always_comb begin
    fetch_cycle_s = (state_r == ST_SRC) ||
                    ((state_r == ST_PAYLOAD) && (bit_cnt_r == 3'd7) && (byte_cnt_r != LAST_BYTE));
    ack0_s = fetch_cycle_s && !src_r && i_req0;
    ack1_s = fetch_cycle_s &&  src_r && i_req1;
    if (ack0_s) begin
      fetch_byte_s = i_data0;
    end else if (ack1_s) begin
      fetch_byte_s = i_data1;
    end else begin
      fetch_byte_s = 8'h00;
    end
  end

  assign o_ack0 = ack0_s;
  assign o_ack1 = ack1_s;

  // Next-state and next-output logic; outputs describe the following cycle.
  always_comb begin
    state_nxt_s    = state_r;
    bit_cnt_nxt_s  = bit_cnt_r;
    byte_cnt_nxt_s = byte_cnt_r;
    shift_nxt_s    = shift_r;
    bit_nxt_s      = 1'b0;
    valid_nxt_s    = 1'b0;
    sof_nxt_s      = 1'b0;
    eof_nxt_s      = 1'b0;
    src_nxt_s      = src_r;
    case (state_r)
      ST_IDLE: begin
        if (gnt_valid_s) begin
          state_nxt_s    = ST_SYNC;
          bit_cnt_nxt_s  = 3'd0;
          byte_cnt_nxt_s = '0;
          bit_nxt_s      = SYNC_WORD[7];
          valid_nxt_s    = 1'b1;
          sof_nxt_s      = 1'b1;
          src_nxt_s      = gnt_idx_s;
        end else begin
          state_nxt_s    = ST_IDLE;
        end
      end
      ST_SYNC: begin
        valid_nxt_s = 1'b1;
        if (bit_cnt_r == 3'd7) begin
          state_nxt_s   = ST_SRC;
          bit_cnt_nxt_s = 3'd0;
          bit_nxt_s     = src_r;
        end else begin
          bit_cnt_nxt_s = bit_cnt_r + 3'd1;
          bit_nxt_s     = SYNC_WORD[3'd6 - bit_cnt_r];
        end
      end
      ST_SRC: begin
        state_nxt_s    = ST_PAYLOAD;
        valid_nxt_s    = 1'b1;
        bit_cnt_nxt_s  = 3'd0;
        byte_cnt_nxt_s = '0;
        bit_nxt_s      = fetch_byte_s[7];
        shift_nxt_s    = {fetch_byte_s[6:0], 1'b0};
      end
      ST_PAYLOAD: begin
        if (bit_cnt_r == 3'd7) begin
          bit_cnt_nxt_s = 3'd0;
          if (byte_cnt_r == LAST_BYTE) begin
            state_nxt_s    = ST_IDLE;
            byte_cnt_nxt_s = '0;
            shift_nxt_s    = 8'h00;
          end else begin
            valid_nxt_s    = 1'b1;
            byte_cnt_nxt_s = byte_cnt_r + BW'(1);
            bit_nxt_s      = fetch_byte_s[7];
            shift_nxt_s    = {fetch_byte_s[6:0], 1'b0};
          end
        end else begin
          valid_nxt_s   = 1'b1;
          bit_cnt_nxt_s = bit_cnt_r + 3'd1;
          bit_nxt_s     = shift_r[7];
          shift_nxt_s   = {shift_r[6:0], 1'b0};
          eof_nxt_s     = (bit_cnt_r == 3'd6) && (byte_cnt_r == LAST_BYTE);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, counters, shift register and registered frame outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= ST_IDLE;
      bit_cnt_r  <= 3'd0;
      byte_cnt_r <= '0;
      shift_r    <= 8'h00;
      bit_r      <= 1'b0;
      valid_r    <= 1'b0;
      sof_r      <= 1'b0;
      eof_r      <= 1'b0;
      src_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      bit_cnt_r  <= bit_cnt_nxt_s;
      byte_cnt_r <= byte_cnt_nxt_s;
      shift_r    <= shift_nxt_s;
      bit_r      <= bit_nxt_s;
      valid_r    <= valid_nxt_s;
      sof_r      <= sof_nxt_s;
      eof_r      <= eof_nxt_s;
      src_r      <= src_nxt_s;
    end
  end

  assign o_bit   = bit_r;
  assign o_valid = valid_r;
  assign o_sof   = sof_r;
  assign o_eof   = eof_r;
  assign o_src   = src_r;

endmodule

// File: tb/tb_crypt_frame_ctrl.sv
// Directed bench for crypt_frame_ctrl at default parameters (A5 sync, 4 bytes).
module tb_crypt_frame_ctrl;
  import crypt_link_pkg::*;

  localparam int FL = 41;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       ack0, ack1, obit, ovalid, osof, oeof, osrc;

  int total = 0;
  int bad   = 0;

  logic [FL-1:0] bits, sofm, eofm, a0m, a1m;
  int            vcnt;

  always #5 clk = ~clk;

  crypt_frame_ctrl dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_req0  (req0),
    .i_req1  (req1),
    .i_data0 (data0),
    .i_data1 (data1),
    .o_ack0  (ack0),
    .o_ack1  (ack1),
    .o_bit   (obit),
    .o_valid (ovalid),
    .o_sof   (osof),
    .o_eof   (oeof),
    .o_src   (osrc)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_sof(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (osof === 1'b1) break;
      @(negedge clk);
    end
    chk(tag, osof, 1'b1);
  endtask

  // Called at frame offset 0; returns at offset FL (first idle cycle).
  task automatic capture(input int drop_after);
    bits = '0; sofm = '0; eofm = '0; a0m = '0; a1m = '0; vcnt = 0;
    for (int i = 0; i < FL; i++) begin
      bits[FL-1-i] = obit;
      sofm[FL-1-i] = osof;
      eofm[FL-1-i] = oeof;
      a0m[FL-1-i]  = ack0;
      a1m[FL-1-i]  = ack1;
      if (ovalid === 1'b1) vcnt++;
      if (i == drop_after) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic chk_frame(input string tag, input logic s, input logic [31:0] pay);
    logic [FL-1:0] exp_bits;
    exp_bits = {8'hA5, s, pay};
    chk({tag, "_bits"}, bits, exp_bits);
    chk({tag, "_vcnt"}, vcnt, frame_len(4));
    chk({tag, "_sof"}, sofm, 41'h100_0000_0000);
    chk({tag, "_eof"}, eofm, 41'h1);
    chk({tag, "_gap"}, ovalid, 1'b0);
    chk({tag, "_src"}, osrc, s);
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_outs", {obit, ovalid, osof, oeof, osrc, ack0, ack1}, 7'b0);

    // Single requester 0, data 3C
    data0 = 8'h3C;
    data1 = 8'hC3;
    req0  = 1'b1;
    @(negedge clk);
    chk("t1_latency", osof, 1'b1);
    capture(40);
    chk_frame("t1", 1'b0, 32'h3C3C_3C3C);
    chk("t1_ack0", a0m, 41'h1_0101_0100);
    chk("t1_ack1", a1m, 41'h0);
    @(negedge clk);
    chk("t1_idle", {ovalid, osof, osrc}, 3'b000);

    // Both requests held: src alternates with one idle cycle between frames
    do_reset();
    data0 = 8'h11;
    data1 = 8'h22;
    req0  = 1'b1;
    req1  = 1'b1;
    for (int f = 0; f < 4; f++) begin
      @(negedge clk);
      chk($sformatf("t2_sof%0d", f), osof, 1'b1);
      capture((f == 3) ? 40 : -1);
      chk_frame($sformatf("t2_f%0d", f), f[0], f[0] ? 32'h2222_2222 : 32'h1111_1111);
    end

    // Requester 1 starves after its first ack
    do_reset();
    data1 = 8'hFF;
    req1  = 1'b1;
    wait_sof("t3_start");
    capture(9);
    chk_frame("t3", 1'b1, 32'hFF00_0000);
    chk("t3_ack1", a1m, 41'h1_0000_0000);
    chk("t3_ack0", a0m, 41'h0);

    // Reset at payload bit 13, restart with requester 1 only
    do_reset();
    data0 = 8'h5A;
    data1 = 8'hC3;
    req0  = 1'b1;
    wait_sof("t4_start");
    repeat (22) @(negedge clk);
    chk("t4_midframe", ovalid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_outs", {obit, ovalid, osof, oeof, osrc}, 5'b0);
    req0  = 1'b0;
    req1  = 1'b1;
    rst_n = 1'b1;
    wait_sof("t4_restart");
    capture(40);
    chk_frame("t4", 1'b1, 32'hC3C3_C3C3);

    // Reset mid-frame after granting 0 must return the pointer to 0
    req0 = 1'b1;
    wait_sof("t5_start");
    chk("t5_first_src", osrc, 1'b0);
    repeat (22) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_outs", {obit, ovalid, osof, oeof, osrc}, 5'b0);
    req0  = 1'b1;
    req1  = 1'b1;
    rst_n = 1'b1;
    wait_sof("t5_restart");
    capture(40);
    chk_frame("t5", 1'b0, 32'h5A5A_5A5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
